// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared widths, CSR numbers and the WB->DE write bundle layout.
package de_regfile_scoreboard_pkg;
   localparam int DBITS     = 32;
   localparam int REGNOBITS = 5;
   localparam int REGWORDS  = 32;
   localparam int CSRNOBITS = 12;
   localparam int CNTBITS   = 2;
   localparam int CSRWORDS  = 4;

   localparam logic [CSRNOBITS-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CSRNOBITS-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CSRNOBITS-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CSRNOBITS-1:0] CSR_MCAUSE  = 12'h342;

   localparam int from_WB_to_DE_WIDTH = 1 + REGNOBITS + DBITS + CSRNOBITS + 1;

   typedef struct packed {
      logic                 wr_reg;
      logic [REGNOBITS-1:0] wregno;
      logic [DBITS-1:0]     regval;
      logic [CSRNOBITS-1:0] wcsrno;
      logic                 wr_csr;
   } wb_to_de_t;

   // Returns {supported, slot}; unsupported numbers map to slot 0 with supported=0.
   function automatic logic [2:0] csr_slot(input logic [CSRNOBITS-1:0] no);
      case (no)
         CSR_MSTATUS: csr_slot = 3'b100;
         CSR_MTVEC:   csr_slot = 3'b101;
         CSR_MEPC:    csr_slot = 3'b110;
         CSR_MCAUSE:  csr_slot = 3'b111;
         default:     csr_slot = 3'b000;
      endcase
   endfunction
endpackage

// File: rtl/de_regfile_scoreboard_sb_counter.sv
// One register's in-flight writer count; underflow flags a WB with nothing outstanding.
module sb_counter
   import de_regfile_scoreboard_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               dec,
   output logic [CNTBITS-1:0] cnt,
   output logic               underflow
);
   assign underflow = dec && (cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: rtl/de_regfile_scoreboard.sv
// DE-stage register/CSR file with WB forwarding and a per-register in-flight
// scoreboard that raises stall_DE on RAW hazards or a saturated destination counter.
module de_regfile_scoreboard
   import de_regfile_scoreboard_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_wr_reg,
   input  logic [REGNOBITS-1:0] wb_wregno,
   input  logic [DBITS-1:0]     wb_regval,
   input  logic [CSRNOBITS-1:0] wb_wcsrno,
   input  logic                 wb_wr_csr,
   input  logic [REGNOBITS-1:0] rs1,
   input  logic [REGNOBITS-1:0] rs2,
   input  logic                 rs1_used,
   input  logic                 rs2_used,
   output logic [DBITS-1:0]     rdata1,
   output logic [DBITS-1:0]     rdata2,
   input  logic [CSRNOBITS-1:0] csr_rno,
   output logic [DBITS-1:0]     csr_rdata,
   input  logic                 issue_valid,
   input  logic                 issue_wr_reg,
   input  logic [REGNOBITS-1:0] issue_rd,
   output logic                 stall_DE,
   output logic                 err_underflow
);
   wb_to_de_t wb;
   assign wb = {wb_wr_reg, wb_wregno, wb_regval, wb_wcsrno, wb_wr_csr};

   logic [DBITS-1:0]   regs [REGWORDS];
   logic [DBITS-1:0]   csrs [CSRWORDS];
   logic [CNTBITS-1:0] cnt  [REGWORDS];
   logic [REGWORDS-1:0] underflow;
   logic [REGWORDS-1:0] busy_eff;
   logic               reg_wr;
   logic               issue_fire;
   logic               rd_full;
   logic [2:0]         wslot;
   logic [2:0]         rslot;

   assign reg_wr = wb.wr_reg && (wb.wregno != '0);
   assign wslot  = csr_slot(wb.wcsrno);
   assign rslot  = csr_slot(csr_rno);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REGWORDS; i++) regs[i] <= '0;
         for (int i = 0; i < CSRWORDS; i++) csrs[i] <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (reg_wr) regs[wb.wregno] <= wb.regval;
         if (wb.wr_csr && wslot[2]) csrs[wslot[1:0]] <= wb.regval;
         if (|underflow) err_underflow <= 1'b1;
      end
   end

   always_comb begin
      rdata1    = '0;
      rdata2    = '0;
      csr_rdata = '0;
      if (!reset) begin
         if (rs1 != '0) rdata1 = (reg_wr && wb.wregno == rs1) ? wb.regval : regs[rs1];
         if (rs2 != '0) rdata2 = (reg_wr && wb.wregno == rs2) ? wb.regval : regs[rs2];
         if (rslot[2])
            csr_rdata = (wb.wr_csr && wb.wcsrno == csr_rno) ? wb.regval : csrs[rslot[1:0]];
      end
   end

   // A WB retiring this cycle removes one writer before the hazard test.
   always_comb begin
      busy_eff = '0;
      for (int r = 0; r < REGWORDS; r++) begin
         if (reg_wr && wb.wregno == REGNOBITS'(r)) busy_eff[r] = (cnt[r] > CNTBITS'(1));
         else                                      busy_eff[r] = (cnt[r] != '0);
      end
   end

   assign rd_full = issue_wr_reg && (cnt[issue_rd] == '1) && !(reg_wr && wb.wregno == issue_rd);
   assign stall_DE = !reset && issue_valid &&
                     ((rs1_used && busy_eff[rs1]) || (rs2_used && busy_eff[rs2]) || rd_full);
   assign issue_fire = issue_valid && !stall_DE;

   assign cnt[0]       = '0;
   assign underflow[0] = 1'b0;

   for (genvar r = 1; r < REGWORDS; r++) begin : g_cnt
      sb_counter u_cnt (
         .clk       (clk),
         .reset     (reset),
         .inc       (issue_fire && issue_wr_reg && issue_rd == REGNOBITS'(r)),
         .dec       (reg_wr && wb.wregno == REGNOBITS'(r)),
         .cnt       (cnt[r]),
         .underflow (underflow[r])
      );
   end
endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Directed checks of forwarding, RAW stalls, counter saturation, CSRs and underflow.
module tb_de_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        reset;
   logic        wb_wr_reg;
   logic [4:0]  wb_wregno;
   logic [31:0] wb_regval;
   logic [11:0] wb_wcsrno;
   logic        wb_wr_csr;
   logic [4:0]  rs1, rs2;
   logic        rs1_used, rs2_used;
   logic [31:0] rdata1, rdata2;
   logic [11:0] csr_rno;
   logic [31:0] csr_rdata;
   logic        issue_valid, issue_wr_reg;
   logic [4:0]  issue_rd;
   logic        stall_DE, err_underflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   de_regfile_scoreboard dut (
      .clk(clk), .reset(reset),
      .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .wb_regval(wb_regval),
      .wb_wcsrno(wb_wcsrno), .wb_wr_csr(wb_wr_csr),
      .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .rdata1(rdata1), .rdata2(rdata2),
      .csr_rno(csr_rno), .csr_rdata(csr_rdata),
      .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
      .stall_DE(stall_DE), .err_underflow(err_underflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_wr_reg = 0; wb_wregno = 0; wb_regval = 0; wb_wcsrno = 0; wb_wr_csr = 0;
      rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; csr_rno = 0;
      issue_valid = 0; issue_wr_reg = 0; issue_rd = 0;
   endtask

   task automatic do_issue(input logic [4:0] rd);
      idle();
      issue_valid = 1; issue_wr_reg = 1; issue_rd = rd;
      tick();
      idle();
   endtask

   task automatic do_wb(input logic [4:0] rd, input logic [31:0] val);
      idle();
      wb_wr_reg = 1; wb_wregno = rd; wb_regval = val;
      tick();
      idle();
   endtask

   task automatic test_reset();
      reset = 1; idle();
      tick(); tick();
      total++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || csr_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rdata: got %h %h %h want 0", rdata1, rdata2, csr_rdata); end
      total++; if (stall_DE !== 1'b0 || err_underflow !== 1'b0) begin
         bad++; $display("FAIL reset_flags: got stall=%b err=%b want 0 0", stall_DE, err_underflow); end
      reset = 0;
      tick();
   endtask

   task automatic test_reset_midop();
      do_issue(5); do_wb(5, 32'h11); do_issue(5); do_issue(5);
      rs1 = 5; rs1_used = 1; issue_valid = 1; #1;
      total++; if (stall_DE !== 1'b1 || rdata1 !== 32'h11) begin
         bad++; $display("FAIL pre_reset: got stall=%b rdata1=%h want 1 00000011", stall_DE, rdata1); end
      #2 reset = 1; #1;
      total++; if (stall_DE !== 1'b0 || rdata1 !== 32'h0 || err_underflow !== 1'b0) begin
         bad++; $display("FAIL in_reset: got stall=%b rdata1=%h err=%b want 0 0 0", stall_DE, rdata1, err_underflow); end
      tick();
      reset = 0; #1;
      total++; if (stall_DE !== 1'b0 || rdata1 !== 32'h0) begin
         bad++; $display("FAIL post_reset: got stall=%b rdata1=%h want 0 0", stall_DE, rdata1); end
      idle(); tick();
   endtask

   task automatic test_forward();
      do_issue(3);
      wb_wr_reg = 1; wb_wregno = 3; wb_regval = 32'hDEADBEEF; rs1 = 3; rs2 = 3; #1;
      total++; if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL fwd_same: got %h %h want deadbeef", rdata1, rdata2); end
      tick();
      wb_wr_reg = 0; wb_regval = 0; #1;
      total++; if (rdata1 !== 32'hDEADBEEF) begin
         bad++; $display("FAIL fwd_array: got %h want deadbeef", rdata1); end
      idle();
   endtask

   task automatic test_raw();
      do_issue(7);
      issue_valid = 1; rs1 = 7; rs1_used = 1; #1;
      total++; if (stall_DE !== 1'b1) begin
         bad++; $display("FAIL raw_c1: got %b want 1", stall_DE); end
      tick();
      total++; if (stall_DE !== 1'b1) begin
         bad++; $display("FAIL raw_c2: got %b want 1", stall_DE); end
      wb_wr_reg = 1; wb_wregno = 7; wb_regval = 32'h42; #1;
      total++; if (stall_DE !== 1'b0 || rdata1 !== 32'h42) begin
         bad++; $display("FAIL raw_clear: got stall=%b rdata1=%h want 0 00000042", stall_DE, rdata1); end
      tick(); idle();
   endtask

   task automatic test_back_to_back();
      do_issue(9);
      issue_valid = 1; issue_wr_reg = 1; issue_rd = 9;
      wb_wr_reg = 1; wb_wregno = 9; wb_regval = 32'h99; #1;
      total++; if (stall_DE !== 1'b0) begin
         bad++; $display("FAIL b2b_fire: got %b want 0", stall_DE); end
      tick(); idle();
      issue_valid = 1; rs1 = 9; rs1_used = 1; #1;
      total++; if (stall_DE !== 1'b1 || rdata1 !== 32'h99) begin
         bad++; $display("FAIL b2b_still_busy: got stall=%b rdata1=%h want 1 00000099", stall_DE, rdata1); end
      tick();
      wb_wr_reg = 1; wb_wregno = 9; wb_regval = 32'hAA; #1;
      total++; if (stall_DE !== 1'b0 || rdata1 !== 32'hAA) begin
         bad++; $display("FAIL b2b_second_wb: got stall=%b rdata1=%h want 0 000000aa", stall_DE, rdata1); end
      tick();
      wb_wr_reg = 0; #1;
      total++; if (stall_DE !== 1'b0) begin
         bad++; $display("FAIL b2b_idle: got %b want 0", stall_DE); end
      idle();
   endtask

   task automatic test_full();
      do_issue(4); do_issue(4); do_issue(4);
      issue_valid = 1; issue_wr_reg = 1; issue_rd = 4; #1;
      total++; if (stall_DE !== 1'b1) begin
         bad++; $display("FAIL full_c1: got %b want 1", stall_DE); end
      tick();
      total++; if (stall_DE !== 1'b1) begin
         bad++; $display("FAIL full_c2: got %b want 1", stall_DE); end
      wb_wr_reg = 1; wb_wregno = 4; wb_regval = 32'h44; #1;
      total++; if (stall_DE !== 1'b0) begin
         bad++; $display("FAIL full_wb: got %b want 0", stall_DE); end
      tick(); idle();
      issue_valid = 1; issue_wr_reg = 1; issue_rd = 4; #1;
      total++; if (stall_DE !== 1'b1) begin
         bad++; $display("FAIL full_again: got %b want 1", stall_DE); end
      idle();
      do_wb(4, 32'h1); do_wb(4, 32'h2); do_wb(4, 32'h3);
      issue_valid = 1; rs1 = 4; rs1_used = 1; rs2 = 4; rs2_used = 1; #1;
      total++; if (stall_DE !== 1'b0 || rdata2 !== 32'h3) begin
         bad++; $display("FAIL full_drained: got stall=%b rdata2=%h want 0 00000003", stall_DE, rdata2); end
      total++; if (err_underflow !== 1'b0) begin
         bad++; $display("FAIL no_err_yet: got %b want 0", err_underflow); end
      idle();
   endtask

   task automatic test_x0_csr_err();
      wb_wr_reg = 1; wb_wregno = 0; wb_regval = 32'h5; rs1 = 0; #1;
      total++; if (rdata1 !== 32'h0) begin
         bad++; $display("FAIL x0_fwd: got %h want 0", rdata1); end
      tick(); idle(); #1;
      total++; if (rdata1 !== 32'h0 || err_underflow !== 1'b0) begin
         bad++; $display("FAIL x0_after: got rdata1=%h err=%b want 0 0", rdata1, err_underflow); end
      wb_wr_csr = 1; wb_wcsrno = 12'h341; wb_regval = 32'h80; csr_rno = 12'h341; #1;
      total++; if (csr_rdata !== 32'h80) begin
         bad++; $display("FAIL csr_fwd: got %h want 00000080", csr_rdata); end
      tick(); idle(); csr_rno = 12'h341; #1;
      total++; if (csr_rdata !== 32'h80) begin
         bad++; $display("FAIL csr_array: got %h want 00000080", csr_rdata); end
      csr_rno = 12'h300; #1;
      total++; if (csr_rdata !== 32'h0) begin
         bad++; $display("FAIL csr_other: got %h want 0", csr_rdata); end
      wb_wr_csr = 1; wb_wcsrno = 12'h123; wb_regval = 32'h55; csr_rno = 12'h123; #1;
      total++; if (csr_rdata !== 32'h0) begin
         bad++; $display("FAIL csr_bad_fwd: got %h want 0", csr_rdata); end
      tick(); idle(); csr_rno = 12'h123; #1;
      total++; if (csr_rdata !== 32'h0) begin
         bad++; $display("FAIL csr_bad_array: got %h want 0", csr_rdata); end
      idle();
      wb_wr_reg = 1; wb_wregno = 6; wb_regval = 32'h66; #1;
      total++; if (err_underflow !== 1'b0) begin
         bad++; $display("FAIL err_early: got %b want 0", err_underflow); end
      tick(); idle(); #1;
      total++; if (err_underflow !== 1'b1) begin
         bad++; $display("FAIL err_set: got %b want 1", err_underflow); end
      tick(); tick(); tick();
      total++; if (err_underflow !== 1'b1) begin
         bad++; $display("FAIL err_sticky: got %b want 1", err_underflow); end
   endtask

   initial begin
      test_reset();
      test_reset_midop();
      test_forward();
      test_raw();
      test_back_to_back();
      test_full();
      test_x0_csr_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/de_regfile_scoreboard.md
Name: de_regfile_scoreboard

Overview:
- Receiving end of the WB→DE register-write bundule {wr_reg, wregno, regval, wcsrno, wr_csr}, instantiated inside the DE stage.
- Holds the 32-entry integer register file and a 4-entry CSR file.
- Provides two register read ports and one CSR read port, with same-cycle write-to-read forwarding from WB.
- Keeps a per-register in-flight counter scoreboard and produces the DE stall signal for RAW hazards on instructions issuing to AGEX.

Parameters:
- DBITS, 32, data width
- REGNOBITS, 5, register number width
- REGWORDS, 32, number of integer registers
- CSRNOBITS, 12, CSR number width
- CNTBITS, 2, per-register in-flight counter width (max 3 in flight: AGEX, MEM, WB)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_wr_reg  in  1  WB writes an integer register this cycle
- wb_wregno  in  REGNOBITS  WB destination register
- wb_regval  in  DBITS  WB write data (register or CSR)
- wb_wcsrno  in  CSRNOBITS  WB destination CSR
- wb_wr_csr  in  1  WB writes a CSR this cycle
- rs1, rs2  in  REGNOBITS each  DE source register numbers
- rs1_used, rs2_used  in  1 each  DE instruction actually reads rs1 / rs2
- rdata1, rdata2  out  DBITS each  source operands (combinational)
- csr_rno  in  CSRNOBITS  CSR read address
- csr_rdata  out  DBITS  CSR read data (combinational)
- issue_valid  in  1  DE holds a live, non-squashed instruction that wants to move to AGEX
- issue_wr_reg  in  1  issuing instruction writes a register
- issue_rd  in  REGNOBITS  issuing instruction destination
- stall_DE  out  1  hold DE/FE this cycle
- err_underflow  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, active-high):
  - All registers, CSRs and counters clear to 0; err_underflow=0.
  - While in reset, stall_DE=0 and rdata/csr_rdata read 0.
- Register x0:
  - Always reads 0.
  - Writes to x0 are ignored; x0 is never counted as busy.
- Register write: on posedge clk, if wb_wr_reg and wb_wregno≠0, then regs[wb_wregno]←wb_regval.
- Forwarding: if wb_wr_reg and wb_wregno==rsN≠0, then rdataN=wb_regval in the same cycle; otherwise rdataN=regs[rsN].
- CSR file:
  - Supported CSRs: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
  - A write to an unsupported number is dropped.
  - A read of an unsupported number returns 0.
  - CSR reads forward from WB exactly as register reads do.
- Scoreboard:
  - Effective busy: busy_eff[r] = cnt[r] − (wb_wr_reg && wb_wregno==r) > 0.
  - stall_DE = issue_valid && ((rs1_used && busy_eff[rs1]) || (rs2_used && busy_eff[rs2]) || (issue_wr_reg && cnt[issue_rd]==3 && no WB hit on issue_rd)).
  - issue_fire = issue_valid && !stall_DE.
  - WAW does not stall: the pipeline is in-order, so counters handle it.
- Counter update, per register r≠0, each posedge:
  - inc = issue_fire && issue_wr_reg && issue_rd==r; dec = wb_wr_reg && wb_wregno==r.
  - inc&&!dec → +1; dec&&!inc → −1; both → unchanged.
- Underflow: dec while cnt==0 leaves the counter at 0 and sets err_underflow, which is sticky until reset.
- Squash: DE/FE instructions killed by an AGEX branch never assert issue_valid. Instructions already past DE always reach WB. No flush port.
- Latency:
  - Write visible to the array on the next cycle, and to readers in the same cycle via forwarding.
  - Stall deasserts in the same cycle that the clearing WB is presented.

Decomposition:
- Shared package / VX_define.vh: DBITS, REGNOBITS, REGWORDS, CSRNOBITS, the CSR number constants, and from_WB_to_DE_WIDTH with the field order {wr_reg, wregno, regval, wcsrno, wr_csr}.
- One sub-module: sb_counter (one per-register up/down counter with underflow detect), instantiated 31×.

Test Plan:
- Reset mid-operation: cnt[5]=2, regs[5]=0x11, reset pulse → all rdata 0, stall 0, err 0.
- WB write + forward: wb x3←0xDEADBEEF with rs1=3 the same cycle → rdata1=0xDEADBEEF; next cycle with no WB → still 0xDEADBEEF.
- RAW stall:
  - issue rd=7, next cycle rs1=7, rs1_used=1 → stall_DE=1 for 2 cycles.
  - The cycle WB presents x7=0x42 → stall_DE=0, rdata1=0x42.
- Simultaneous issue and WB to x9 with cnt[9]=1 → cnt stays 1; a later reader of x9 still stalls until the second WB.
- Counter full: three issues to x4 with no WB → cnt=3; a fourth issue with rd=4 → stall_DE=1 until a WB to x4 arrives.
- x0/CSR/error:
  - wb x0←5 → x0 reads 0.
  - wb CSR 0x341←0x80 → csr_rdata=0x80.
  - wb CSR 0x123 → dropped, reads 0.
  - wb x6 with cnt[6]=0 → err_underflow=1 and sticky.
